scope_capture_ctrl: RTL and testbench
=====================================

# scope_capture_ctrl

Acquisition sequencer for the flash-ADC write side of the oscilloscope sample FIFO. It arms on command, watches the decimated sample stream for a level crossing, and writes exactly DEPTH samples into the FIFO starting at the trigger sample. It then waits for the UART side to drain the FIFO completely, and re-arms after a hold-off in normal mode. It replaces the free-running fill/stop logic and runs entirely in the sample clock domain.

## Interface
- DW, 8: sample width.
- DEPTH, 512: samples per capture; must be ≤ FIFO depth.
- HOLDOFF, 1024: clk cycles between drain-complete and re-arm.
- AUTO_TIMEOUT, 65535: clk cycles in ARMED before forced trigger; used only with the macro.

- clk  in  1  sample clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse; starts acquisition from IDLE.
- stop  in  1  abort; returns to IDLE from any state.
- mode  in  1  0 = single shot, 1 = normal (auto re-arm).
- slope  in  1  0 = rising crossing, 1 = falling crossing.
- trig_level  in  DW  unsigned trigger threshold.
- decim  in  4  keep 1 of every decim+1 valid samples.
- s_valid  in  1  s_data is valid this cycle.
- s_data  in  DW  ADC sample.
- fifo_wrfull  in  1  FIFO write-side full.
- fifo_wrempty  in  1  FIFO write-side empty.
- fifo_wrreq  out  1  FIFO write strobe.
- fifo_data  out  DW  FIFO write data.
- state  out  3  current state.
- triggered  out  1  one-cycle pulse on trigger.
- overflow  out  1  sticky; a capture write was dropped.
- auto_fired  out  1  sticky; the last trigger was forced.

## Operation
- State encoding: IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3, HOLDOFF=4.
- Decimation:
  - Counter reloads to decim on arm and on every accepted sample.
  - A sample is accepted when s_valid=1 and the counter is 0; otherwise the counter decrements on each s_valid.
  - decim=0 accepts every valid sample.
- Trigger detect, on accepted samples only, unsigned compare against prev (last accepted sample):
  - Rising: prev < trig_level and s_data >= trig_level.
  - Falling: prev >= trig_level and s_data < trig_level.
  - No trigger is possible until prev is valid; prev_valid is cleared on entry to ARMED.
- IDLE: arm → ARMED; overflow and auto_fired are cleared on arm.
- ARMED: trigger → CAPTURE; the trigger sample is write #1.
- CAPTURE:
  - Each accepted sample is written.
  - After write DEPTH, go to DRAIN.
  - If fifo_wrfull=1 when a write is due: drop the sample, set overflow, go to DRAIN.
- DRAIN: fifo_wrempty=1 → HOLDOFF if mode=1, else IDLE.
- HOLDOFF: count HOLDOFF cycles, then ARMED.
- stop: goes to IDLE next cycle from any state; no further writes; counters cleared. stop beats a simultaneous arm.
- arm outside IDLE is ignored.
- Reset values: state IDLE, fifo_wrreq 0, fifo_data 0, triggered 0, overflow 0, auto_fired 0, all counters 0.

## Timing
- Accepted sample at edge n → fifo_wrreq=1 and fifo_data=sample for cycle n+1; all outputs are registered.
- triggered pulses in the same cycle as the first fifo_wrreq.
- fifo_wrreq is high for at most one cycle per accepted sample.
- Capture write count is exactly DEPTH unless overflow or stop intervenes.
- DRAIN exit is 1 cycle after fifo_wrempty is sampled high.
- HOLDOFF lasts exactly HOLDOFF cycles.

## Configuration
- SCOPE_AUTO_TRIG_EN defined:
  - A cycle counter runs in ARMED and is cleared on entry.
  - When it reaches AUTO_TIMEOUT, the next accepted sample is treated as the trigger and auto_fired is set.
- SCOPE_AUTO_TRIG_EN undefined: no timeout counter; ARMED waits indefinitely; auto_fired is tied to 0.

## Structure
- Package scope_pkg holds the state enum, the DW default, and the state encoding constants.
- Sub-module scope_trig_detect holds the prev register, prev_valid, and the slope/level compare. It outputs a one-cycle hit qualified by the accept strobe.

## Test plan
- Rising trigger: mode=0, slope=0, level=0x80, decim=0, DEPTH=16, ramp 0x70..0x9F after arm. Required: first write=0x80, 16 writes, then DRAIN; fifo_wrempty → IDLE.
- Falling trigger with decim=2: descending ramp. Required: only every 3rd valid sample is written; the trigger is the first kept sample < level.
- Overflow: hold fifo_wrfull=1 at capture write 5. Required: 4 writes, overflow=1, DRAIN.
- Normal mode: mode=1, HOLDOFF=8. Required: after wrempty, exactly 8 cycles in HOLDOFF, then ARMED; a second capture follows the next crossing.
- stop mid-CAPTURE after write 3, with arm in the same cycle. Required: IDLE next cycle, no further fifo_wrreq.
- With SCOPE_AUTO_TRIG_EN, AUTO_TIMEOUT=100, constant input 0x10. Required: trigger at the first accepted sample after 100 cycles, auto_fired=1.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and constants for the scope acquisition sequencer.
// State encoding is fixed because the state value is exported on a port.
package scope_pkg;

  localparam int DW_DEFAULT = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ARMED   = ST_ARMED,
    S_CAPTURE = ST_CAPTURE,
    S_DRAIN   = ST_DRAIN,
    S_HOLDOFF = ST_HOLDOFF
  } state_t;

endpackage

// File: rtl/scope_trig_detect.sv
// Level-crossing detector on the decimated sample stream: keeps the last
// accepted sample and flags a rising or falling crossing of the threshold.
module scope_trig_detect
  import scope_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          accept,
  input  logic          slope,
  input  logic [DW-1:0] level,
  input  logic [DW-1:0] sample,
  output logic          hit
);

  logic [DW-1:0] prev;
  logic          prev_valid;
  logic          rise;
  logic          fall;

  assign rise = (prev < level) && (sample >= level);
  assign fall = (prev >= level) && (sample < level);
  assign hit  = accept && prev_valid && (slope ? fall : rise);

  // clear wins over a same-cycle accept so a fresh arm never compares
  // against a sample taken before the arm point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (accept)
        prev <= sample;
      if (clear)
        prev_valid <= 1'b0;
      else if (accept)
        prev_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Write-side acquisition sequencer for the scope sample FIFO.
// Optional forced trigger after a timeout in ARMED: define SCOPE_AUTO_TRIG_EN.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int DW           = DW_DEFAULT,
  parameter int DEPTH        = 512,
  parameter int HOLDOFF      = 1024,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          stop,
  input  logic          mode,
  input  logic          slope,
  input  logic [DW-1:0] trig_level,
  input  logic [3:0]    decim,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          fifo_wrfull,
  input  logic          fifo_wrempty,
  output logic          fifo_wrreq,
  output logic [DW-1:0] fifo_data,
  output logic [2:0]    state,
  output logic          triggered,
  output logic          overflow,
  output logic          auto_fired
);

  localparam int WCW = $clog2(DEPTH + 1);
  localparam int HCW = $clog2(HOLDOFF + 1);

  state_t         cur_state, nxt_state;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [HCW-1:0] hcnt, hcnt_n;
  logic [3:0]     dcnt, dcnt_n;
  logic           wrreq_n, trig_n, ovf_n;
  logic [DW-1:0]  data_n;
  logic           accept, hit, force_trig, take_trig, enter_armed;

  assign accept    = s_valid && (dcnt == 4'd0);
  assign take_trig = (cur_state == S_ARMED) && accept && (hit || force_trig) && !stop;
  assign state     = cur_state;

  scope_trig_detect #(.DW(DW)) u_trig (
    .clk    (clk),
    .rst    (rst),
    .clear  (enter_armed),
    .accept (accept),
    .slope  (slope),
    .level  (trig_level),
    .sample (s_data),
    .hit    (hit)
  );

  // Next-state and next-output logic; stop overrides everything at the end
  always_comb begin
    nxt_state   = cur_state;
    wcnt_n      = wcnt;
    hcnt_n      = hcnt;
    dcnt_n      = dcnt;
    wrreq_n     = 1'b0;
    data_n      = fifo_data;
    trig_n      = 1'b0;
    ovf_n       = overflow;
    enter_armed = 1'b0;

    if (accept)
      dcnt_n = decim;
    else if (s_valid)
      dcnt_n = dcnt - 4'd1;

    case (cur_state)
      S_IDLE: begin
        if (arm) begin
          nxt_state   = S_ARMED;
          ovf_n       = 1'b0;
          dcnt_n      = decim;
          enter_armed = 1'b1;
        end
      end
      S_ARMED: begin
        if (take_trig) begin
          trig_n = 1'b1;
          if (fifo_wrfull) begin
            ovf_n     = 1'b1;
            nxt_state = S_DRAIN;
          end else begin
            wrreq_n   = 1'b1;
            data_n    = s_data;
            wcnt_n    = WCW'(1);
            nxt_state = (DEPTH == 1) ? S_DRAIN : S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (accept) begin
          if (fifo_wrfull) begin
            ovf_n     = 1'b1;
            nxt_state = S_DRAIN;
          end else begin
            wrreq_n = 1'b1;
            data_n  = s_data;
            wcnt_n  = wcnt + WCW'(1);
            if (wcnt == WCW'(DEPTH - 1))
              nxt_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_wrempty) begin
          wcnt_n    = '0;
          hcnt_n    = '0;
          nxt_state = mode ? S_HOLDOFF : S_IDLE;
        end
      end
      S_HOLDOFF: begin
        if (hcnt == HCW'(HOLDOFF - 1)) begin
          hcnt_n      = '0;
          nxt_state   = S_ARMED;
          enter_armed = 1'b1;
        end else begin
          hcnt_n = hcnt + HCW'(1);
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    if (stop) begin
      nxt_state   = S_IDLE;
      wcnt_n      = '0;
      hcnt_n      = '0;
      dcnt_n      = '0;
      wrreq_n     = 1'b0;
      data_n      = fifo_data;
      trig_n      = 1'b0;
      ovf_n       = overflow;
      enter_armed = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= S_IDLE;
      wcnt       <= '0;
      hcnt       <= '0;
      dcnt       <= '0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      triggered  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      wcnt       <= wcnt_n;
      hcnt       <= hcnt_n;
      dcnt       <= dcnt_n;
      fifo_wrreq <= wrreq_n;
      fifo_data  <= data_n;
      triggered  <= trig_n;
      overflow   <= ovf_n;
    end
  end

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int ACW = $clog2(AUTO_TIMEOUT + 1);

  logic [ACW-1:0] acnt;
  logic           auto_q;

  assign force_trig = (cur_state == S_ARMED) && (acnt == ACW'(AUTO_TIMEOUT));
  assign auto_fired = auto_q;

  // Timeout saturates so a forced trigger stays pending until a sample arrives;
  // auto_fired records whether the most recent trigger was the forced one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acnt   <= '0;
      auto_q <= 1'b0;
    end else begin
      if (stop || enter_armed || cur_state != S_ARMED)
        acnt <= '0;
      else if (acnt != ACW'(AUTO_TIMEOUT))
        acnt <= acnt + ACW'(1);
      if (!stop && cur_state == S_IDLE && arm)
        auto_q <= 1'b0;
      else if (take_trig)
        auto_q <= !hit;
    end
  end
`else
  assign force_trig = (AUTO_TIMEOUT < 0);
  assign auto_fired = 1'b0;
`endif

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: rising, decimated falling, overflow,
// normal-mode hold-off, stop-with-arm, and forced trigger when SCOPE_AUTO_TRIG_EN.
module tb_scope_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm, stop, mode, slope;
  logic [7:0] trig_level;
  logic [3:0] decim;
  logic       s_valid;
  logic [7:0] s_data;
  logic       fifo_wrfull, fifo_wrempty;
  logic       fifo_wrreq;
  logic [7:0] fifo_data;
  logic [2:0] state;
  logic       triggered, overflow, auto_fired;

  int errors = 0;
  int checks = 0;
  int nwr;

  always #5 clk = ~clk;

  scope_capture_ctrl #(
    .DW(8), .DEPTH(16), .HOLDOFF(8), .AUTO_TIMEOUT(100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .stop         (stop),
    .mode         (mode),
    .slope        (slope),
    .trig_level   (trig_level),
    .decim        (decim),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .fifo_wrfull  (fifo_wrfull),
    .fifo_wrempty (fifo_wrempty),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_data    (fifo_data),
    .state        (state),
    .triggered    (triggered),
    .overflow     (overflow),
    .auto_fired   (auto_fired)
  );

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic armPulse();
    arm = 1'b1;
    applyStimulus(1'b0, 8'h00);
    arm = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    logic       exp_wr;

    rst = 1'b1; arm = 1'b0; stop = 1'b0; mode = 1'b0; slope = 1'b0;
    trig_level = 8'h80; decim = 4'd0; s_valid = 1'b0; s_data = 8'h00;
    fifo_wrfull = 1'b0; fifo_wrempty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_state", state, 3'd0);
    checkOutput("rst_wrreq", fifo_wrreq, 1'b0);
    checkOutput("rst_data", fifo_data, 8'h00);
    checkOutput("rst_trig", triggered, 1'b0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_auto", auto_fired, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00);

    $display("[TB] rising trigger, single shot");
    armPulse();
    checkOutput("t1_armed", state, 3'd1);
    nwr = 0;
    for (int i = 8'h70; i <= 8'h9F; i++) begin
      v = 8'(i);
      applyStimulus(1'b1, v);
      exp_wr = (v >= 8'h80) && (v <= 8'h8F);
      checkOutput("t1_wrreq", fifo_wrreq, exp_wr);
      checkOutput("t1_trig", triggered, v == 8'h80);
      if (exp_wr) checkOutput("t1_data", fifo_data, v);
      nwr += fifo_wrreq;
    end
    checkOutput("t1_count", nwr, 16);
    checkOutput("t1_drain", state, 3'd3);
    fifo_wrempty = 1'b1;
    applyStimulus(1'b0, 8'h00);
    fifo_wrempty = 1'b0;
    checkOutput("t1_idle", state, 3'd0);

    $display("[TB] falling trigger, decim=2");
    slope = 1'b1; decim = 4'd2;
    armPulse();
    nwr = 0;
    for (int k = 1; k <= 84; k++) begin
      v = 8'h A0 - 8'(k - 1);
      applyStimulus(1'b1, v);
      exp_wr = (k % 3 == 0) && (v <= 8'h7D) && (v >= 8'h50);
      checkOutput("t2_wrreq", fifo_wrreq, exp_wr);
      checkOutput("t2_trig", triggered, (k % 3 == 0) && (v == 8'h7D));
      if (exp_wr) checkOutput("t2_data", fifo_data, v);
      nwr += fifo_wrreq;
      if (k % 4 == 0) begin
        applyStimulus(1'b0, 8'hFF);
        checkOutput("t2_gap", fifo_wrreq, 1'b0);
      end
    end
    checkOutput("t2_count", nwr, 16);
    checkOutput("t2_drain", state, 3'd3);
    fifo_wrempty = 1'b1;
    applyStimulus(1'b0, 8'h00);
    fifo_wrempty = 1'b0;
    checkOutput("t2_idle", state, 3'd0);

    $display("[TB] overflow at write 5");
    slope = 1'b0; decim = 4'd0;
    armPulse();
    nwr = 0;
    for (int i = 8'h70; i <= 8'h84; i++) begin
      v = 8'(i);
      fifo_wrfull = (v == 8'h84);
      applyStimulus(1'b1, v);
      checkOutput("t3_wrreq", fifo_wrreq, (v >= 8'h80) && (v <= 8'h83));
      nwr += fifo_wrreq;
    end
    fifo_wrfull = 1'b0;
    checkOutput("t3_count", nwr, 4);
    checkOutput("t3_ovf", overflow, 1'b1);
    checkOutput("t3_drain", state, 3'd3);
    applyStimulus(1'b1, 8'h85);
    checkOutput("t3_nowr", fifo_wrreq, 1'b0);
    fifo_wrempty = 1'b1;
    applyStimulus(1'b0, 8'h00);
    fifo_wrempty = 1'b0;
    checkOutput("t3_idle", state, 3'd0);
    checkOutput("t3_sticky", overflow, 1'b1);

    $display("[TB] normal mode, hold-off, stop with arm");
    mode = 1'b1;
    armPulse();
    checkOutput("t4_armed", state, 3'd1);
    checkOutput("t4_ovf_clr", overflow, 1'b0);
    nwr = 0;
    for (int i = 8'h70; i <= 8'h8F; i++) begin
      applyStimulus(1'b1, 8'(i));
      nwr += fifo_wrreq;
    end
    checkOutput("t4_count", nwr, 16);
    checkOutput("t4_drain", state, 3'd3);
    applyStimulus(1'b1, 8'h10);
    checkOutput("t4_drain_hold", state, 3'd3);
    fifo_wrempty = 1'b1;
    applyStimulus(1'b0, 8'h00);
    fifo_wrempty = 1'b0;
    checkOutput("t4_hold0", state, 3'd4);
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput("t4_hold", state, 3'd4);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_rearm", state, 3'd1);
    applyStimulus(1'b1, 8'h90);
    checkOutput("t4_noprev", fifo_wrreq, 1'b0);
    applyStimulus(1'b1, 8'h10);
    checkOutput("t4_low", fifo_wrreq, 1'b0);
    applyStimulus(1'b1, 8'h90);
    checkOutput("t4_trig", triggered, 1'b1);
    checkOutput("t4_w1", fifo_data, 8'h90);
    checkOutput("t4_cap", state, 3'd2);
    applyStimulus(1'b1, 8'h91);
    checkOutput("t4_w2", fifo_data, 8'h91);
    applyStimulus(1'b1, 8'h92);
    checkOutput("t4_w3", fifo_wrreq, 1'b1);
    stop = 1'b1; arm = 1'b1;
    applyStimulus(1'b1, 8'h93);
    stop = 1'b0; arm = 1'b0;
    checkOutput("t5_idle", state, 3'd0);
    checkOutput("t5_nowr", fifo_wrreq, 1'b0);
    applyStimulus(1'b1, 8'h94);
    checkOutput("t5_nowr2", fifo_wrreq, 1'b0);
    checkOutput("t5_still_idle", state, 3'd0);
    mode = 1'b0;

`ifdef SCOPE_AUTO_TRIG_EN
    $display("[TB] forced trigger after timeout");
    armPulse();
    for (int c = 1; c <= 100; c++) begin
      applyStimulus(1'b1, 8'h10);
      checkOutput("t6_wait", fifo_wrreq, 1'b0);
    end
    applyStimulus(1'b1, 8'h10);
    checkOutput("t6_wrreq", fifo_wrreq, 1'b1);
    checkOutput("t6_trig", triggered, 1'b1);
    checkOutput("t6_auto", auto_fired, 1'b1);
    stop = 1'b1;
    applyStimulus(1'b0, 8'h00);
    stop = 1'b0;
`else
    checkOutput("t6_auto_tied", auto_fired, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
